// File: rtl/i2c_mux_bridge.sv
// i2c_mux_bridge: connects one upstream I2C master to one of NUM_CH downstream
// channels. SDA and SCL each have an independent direction FSM that works out
// which side pulled the line low and mirrors that low onto the other side.
// Pads are open-drain only: they are driven 0 or released.

module i2c_mux_bridge #(
   parameter int NUM_CH      = 4,
   parameter int SEL_W       = 2,
   parameter int SYNC_STAGES = 2,
   parameter int HOLDOFF     = 10,
   parameter int TIMEOUT     = 65535
) (
   input  logic              clk,
   input  logic              resetb,
   input  logic              enable,
   input  logic [SEL_W-1:0]  ch_sel,
   inout  wire               sda_master,
   inout  wire               scl_master,
   inout  wire  [NUM_CH-1:0] sda_slave,
   inout  wire  [NUM_CH-1:0] scl_slave,
   output logic [SEL_W-1:0]  active_ch,
   output logic              busy,
   output logic              stuck
);

   localparam int HW = $clog2(HOLDOFF + 2);
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLDOFF);
   localparam logic [15:0]   TO_LAST  = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, M2S, S2M} dir_t;

   logic [SYNC_STAGES-1:0] sda_m_sync;
   logic [SYNC_STAGES-1:0] scl_m_sync;
   logic [NUM_CH-1:0]      sda_s_sync [SYNC_STAGES];
   logic [NUM_CH-1:0]      scl_s_sync [SYNC_STAGES];

   logic              sda_m;
   logic              scl_m;
   logic [NUM_CH-1:0] sda_s_vec;
   logic [NUM_CH-1:0] scl_s_vec;
   logic              sda_s_act;
   logic              scl_s_act;
   logic              sda_m_prev;
   logic              ch_ok;

   // Index 0 is the SDA FSM, index 1 is the SCL FSM.
   dir_t          state    [2];
   logic [HW-1:0] hold_cnt [2];
   logic [15:0]   to_cnt   [2];
   logic [1:0]    oe_m;
   logic [1:0]    oe_s;
   logic [1:0]    blk_m2s;
   logic [1:0]    blk_s2m;
   logic [1:0]    m_line;
   logic [1:0]    s_line;

   assign sda_m     = sda_m_sync[SYNC_STAGES-1];
   assign scl_m     = scl_m_sync[SYNC_STAGES-1];
   assign sda_s_vec = sda_s_sync[SYNC_STAGES-1];
   assign scl_s_vec = scl_s_sync[SYNC_STAGES-1];
   assign m_line    = {scl_m, sda_m};
   assign s_line    = {scl_s_act, sda_s_act};
   assign ch_ok     = ({1'b0, ch_sel} < (SEL_W+1)'(NUM_CH));

   // Resynchronise every pad into clk; lines idle high so the chains reset to 1.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         sda_m_sync <= '1;
         scl_m_sync <= '1;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sda_s_sync[i] <= '1;
            scl_s_sync[i] <= '1;
         end
      end else begin
         sda_m_sync    <= {sda_m_sync[SYNC_STAGES-2:0], sda_master};
         scl_m_sync    <= {scl_m_sync[SYNC_STAGES-2:0], scl_master};
         sda_s_sync[0] <= sda_slave;
         scl_s_sync[0] <= scl_slave;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sda_s_sync[i] <= sda_s_sync[i-1];
            scl_s_sync[i] <= scl_s_sync[i-1];
         end
      end
   end

   // Pick out the synchronised lines of the currently connected channel.
   always_comb begin
      sda_s_act = 1'b1;
      scl_s_act = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         if (active_ch == SEL_W'(i)) begin
            sda_s_act = sda_s_vec[i];
            scl_s_act = scl_s_vec[i];
         end
      end
   end

   // Direction FSMs: a timeout blocks both the stuck source and the echo of
   // our own released drive until each line has been seen high again.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         for (int l = 0; l < 2; l++) begin
            state[l]    <= IDLE;
            hold_cnt[l] <= '0;
            to_cnt[l]   <= '0;
         end
         oe_m    <= '0;
         oe_s    <= '0;
         blk_m2s <= '0;
         blk_s2m <= '0;
         stuck   <= 1'b0;
      end else if (!enable) begin
         for (int l = 0; l < 2; l++) begin
            state[l]    <= IDLE;
            hold_cnt[l] <= '0;
            to_cnt[l]   <= '0;
         end
         oe_m    <= '0;
         oe_s    <= '0;
         blk_m2s <= '0;
         blk_s2m <= '0;
         stuck   <= 1'b0;
      end else begin
         for (int l = 0; l < 2; l++) begin
            if (m_line[l]) blk_m2s[l] <= 1'b0;
            if (s_line[l]) blk_s2m[l] <= 1'b0;
            case (state[l])
               IDLE: begin
                  oe_m[l]     <= 1'b0;
                  oe_s[l]     <= 1'b0;
                  hold_cnt[l] <= '0;
                  to_cnt[l]   <= '0;
                  if (!m_line[l] && !blk_m2s[l]) begin
                     state[l] <= M2S;
                     oe_s[l]  <= 1'b1;
                  end else if (!s_line[l] && !blk_s2m[l]) begin
                     state[l] <= S2M;
                     oe_m[l]  <= 1'b1;
                  end
               end
               M2S: begin
                  if (!m_line[l]) begin
                     hold_cnt[l] <= '0;
                     if (oe_s[l] && to_cnt[l] == TO_LAST) begin
                        oe_s[l]    <= 1'b0;
                        state[l]   <= IDLE;
                        stuck      <= 1'b1;
                        blk_m2s[l] <= 1'b1;
                        blk_s2m[l] <= 1'b1;
                     end else begin
                        oe_s[l] <= 1'b1;
                        if (oe_s[l]) to_cnt[l] <= to_cnt[l] + 16'd1;
                     end
                  end else begin
                     oe_s[l] <= 1'b0;
                     if (hold_cnt[l] < HOLD_MAX) hold_cnt[l] <= hold_cnt[l] + 1'b1;
                     if (s_line[l] || hold_cnt[l] >= HOLD_MAX) state[l] <= IDLE;
                  end
               end
               S2M: begin
                  if (!s_line[l]) begin
                     hold_cnt[l] <= '0;
                     if (oe_m[l] && to_cnt[l] == TO_LAST) begin
                        oe_m[l]    <= 1'b0;
                        state[l]   <= IDLE;
                        stuck      <= 1'b1;
                        blk_m2s[l] <= 1'b1;
                        blk_s2m[l] <= 1'b1;
                     end else begin
                        oe_m[l] <= 1'b1;
                        if (oe_m[l]) to_cnt[l] <= to_cnt[l] + 16'd1;
                     end
                  end else begin
                     oe_m[l] <= 1'b0;
                     if (hold_cnt[l] < HOLD_MAX) hold_cnt[l] <= hold_cnt[l] + 1'b1;
                     if (m_line[l] || hold_cnt[l] >= HOLD_MAX) state[l] <= IDLE;
                  end
               end
               default: state[l] <= IDLE;
            endcase
         end
      end
   end

   // START/STOP detection on the synchronised master lines drives busy.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         sda_m_prev <= 1'b1;
         busy       <= 1'b0;
      end else begin
         sda_m_prev <= sda_m;
         if (!enable)                            busy <= 1'b0;
         else if (scl_m && sda_m_prev && !sda_m) busy <= 1'b1;
         else if (scl_m && !sda_m_prev && sda_m) busy <= 1'b0;
      end
   end

   // Channel selection only follows ch_sel while the bus is quiet.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         active_ch <= '0;
      end else if (ch_ok && (!enable || (!busy && state[0] == IDLE && state[1] == IDLE))) begin
         active_ch <= ch_sel;
      end
   end

   assign sda_master = (oe_m[0] && !sda_s_act) ? 1'b0 : 1'bz;
   assign scl_master = (oe_m[1] && !scl_s_act) ? 1'b0 : 1'bz;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_slave_pad
      assign sda_slave[g] = (oe_s[0] && !sda_m && active_ch == SEL_W'(g)) ? 1'b0 : 1'bz;
      assign scl_slave[g] = (oe_s[1] && !scl_m && active_ch == SEL_W'(g)) ? 1'b0 : 1'bz;
   end

endmodule
